nios_system_pio_in_edge: RTL and testbench
==========================================

NIOS_SYSTEM_PIO_IN_EDGE -- requirements
Module: nios_system_pio_in_edge

Interface
REQ-001 Parameter WIDTH, 8: in_port width, 1..32.
REQ-002 Parameter EDGE_TYPE, 0: capture edge type; 0 rising, 1 falling, 2 any.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 in_port  input  WIDTH  external asynchronous input pins.
REQ-011 irq  output  1  level interrupt to processor.

Function
REQ-012 The register map SHALL be: 0 data (RO), 1 reserved (reads 0), 2 irq_mask (RW), 3 edge_capture (R, write-1-to-clear).
REQ-013 readdata SHALL register each cycle the selected register, zero-extended to 32 bits; read latency is one cycle from address valid.
REQ-014 Write SHALL occur when chipselect && !write_n; writes to addresses 0 and 1 SHALL be ignored.
REQ-015 A write to address 2 SHALL load irq_mask <= writedata[WIDTH-1:0].
REQ-016 The sampled value data_in SHALL be held in a register; prev SHALL hold data_in delayed one cycle.
REQ-017 Edge detection, per bit: rising = data_in & ~prev; falling = ~data_in & prev; any = data_in ^ prev.
REQ-018 A detected edge SHALL set the matching edge_capture bit on the next clock; the bit SHALL remain set until cleared.
REQ-019 A write to address 3 SHALL clear each edge_capture bit whose writedata bit is 1; bits written 0 SHALL be unchanged.
REQ-020 If a clear and a new edge hit the same bit in the same cycle, set SHALL win.
REQ-021 irq SHALL be combinational: |(edge_capture & irq_mask).
REQ-022 Pulses on in_port shorter than one clk period SHALL NOT be guaranteed detected; pulses of 2+ cycles SHALL be detected.
REQ-023 Writing irq_mask to 0 SHALL deassert irq in the same cycle the register updates, without clearing edge_capture.

Reset
REQ-024 Reset SHALL zero data_in, prev, synchronizer flops, irq_mask, edge_capture and readdata; irq SHALL be 0 during reset.
REQ-025 Reset asserted mid-operation SHALL discard pending captures immediately (asynchronously).
REQ-026 An in_port bit high at reset release SHALL be captured as a rising edge (prev resets to 0).

Configuration
REQ-027 Macro NIOS_PIO_IN_SYNC_EN defined: in_port SHALL pass through a two-flop synchronizer before data_in; in_port-to-data latency 3 cycles, in_port-to-edge_capture 4 cycles.
REQ-028 Macro undefined: data_in SHALL sample in_port directly; in_port-to-data latency 1 cycle, in_port-to-edge_capture 2 cycles.

Structure
REQ-029 Package nios_pio_pkg SHALL hold register address constants (ADDR_DATA, ADDR_MASK, ADDR_EDGE) and EDGE_TYPE encodings.
REQ-030 Sub-module nios_pio_edge_detect (WIDTH, EDGE_TYPE; in: data_in, prev; out: edge vector) SHALL implement REQ-017.

Verification
REQ-031 Rising edge: WIDTH=8, EDGE_TYPE=0, mask=0x01, in_port 0x00->0x01 -> edge_capture=0x01 at documented latency, irq=1; read address 3 returns 0x00000001.
REQ-032 Clear: write 0x01 to address 3 -> edge_capture=0x00, irq=0 next cycle; write 0x00 leaves bits unchanged.
REQ-033 Set-wins: edge on bit 2 in the same cycle as clear write 0x04 -> edge_capture bit 2 remains 1.
REQ-034 Masking: capture 0x80, mask=0x00 -> irq=0; write mask 0x80 -> irq=1 without new edge.
REQ-035 EDGE_TYPE=2: in_port 0x0F->0xF0 -> edge_capture=0xFF; address 0 reads 0x000000F0; address 1 reads 0.
REQ-036 Reset mid-capture: edge_capture=0x3C, assert reset asynchronously -> all registers and irq 0 before next clk edge; in_port held 0x01 at release -> bit 0 captured.

Source files
------------

// File: rtl/nios_pio_pkg.sv
// Shared register map and edge-type encodings for the PIO input-edge block.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_edge_detect.sv
// Per-bit edge detector: compares the current sample against the previous one.
module nios_pio_edge_detect
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] prev,
  output logic [WIDTH-1:0] edges
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edges[i] = data_in[i] & ~prev[i];
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edges[i] = ~data_in[i] & prev[i];
    end else begin : g_any
      assign edges[i] = data_in[i] ^ prev[i];
    end
  end

endmodule

// File: rtl/nios_system_pio_in_edge.sv
// Avalon-MM input PIO with edge capture and masked level interrupt.
// Define NIOS_PIO_IN_SYNC_EN to add a two-flop synchronizer ahead of data_in.
module nios_system_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr_en;

`ifdef NIOS_PIO_IN_SYNC_EN
  logic [WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  assign sampled = sync2;
`else
  assign sampled = in_port;
`endif

  nios_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .data_in (data_in),
    .prev    (prev),
    .edges   (edges)
  );

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = data_in;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux = '0;
    endcase
  end

  // prev resets to 0 so a pin already high at release counts as a rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in      <= '0;
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      data_in  <= sampled;
      prev     <= data_in;
      readdata <= rd_mux;
      if (wr_en && address == ADDR_MASK)
        irq_mask <= writedata[WIDTH-1:0];
      // a fresh edge beats a simultaneous clear
      edge_capture <= (edge_capture & ~clr) | edges;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Bench: rising-edge and any-edge instances on a shared bus, checked against a sample-history model.
module tb_nios_system_pio_in_edge;

`ifdef NIOS_PIO_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata0, readdata2;
  logic        irq0, irq2;

  int checks = 0;
  int errors = 0;

  // model state: hist[k] is in_port as sampled k+1 edges ago
  logic [7:0] hist [0:LAT];
  logic [7:0] m_cap0, m_cap2, m_mask;
  logic [31:0] m_rd0, m_rd2;

  always #5 clk = ~clk;

  nios_system_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata0),
    .in_port(in_port), .irq(irq0)
  );

  nios_system_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port), .irq(irq2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k <= LAT; k++) hist[k] = '0;
    m_cap0 = '0; m_cap2 = '0; m_mask = '0; m_rd0 = '0; m_rd2 = '0;
  endtask

  function automatic logic [31:0] sel(input logic [1:0] a, input logic [7:0] d, input logic [7:0] c);
    case (a)
      2'd0:    return {24'd0, d};
      2'd2:    return {24'd0, m_mask};
      2'd3:    return {24'd0, c};
      default: return 32'd0;
    endcase
  endfunction

  // advance one clock, updating the model from the pre-edge inputs, then check outputs
  task automatic tick();
    logic [7:0] di, pv, clr;
    logic wr;
    di = hist[LAT-1];
    pv = hist[LAT];
    wr = chipselect && !write_n;
    m_rd0 = sel(address, di, m_cap0);
    m_rd2 = sel(address, di, m_cap2);
    clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
    if (wr && address == 2'd2) m_mask = writedata[7:0];
    m_cap0 = (m_cap0 & ~clr) | (di & ~pv);
    m_cap2 = (m_cap2 & ~clr) | (di ^ pv);
    for (int k = LAT; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = in_port;
    @(posedge clk);
    #1;
    chk("rd_rise", readdata0, m_rd0);
    chk("rd_any",  readdata2, m_rd2);
    chk("irq_rise", {31'd0, irq0}, {31'd0, |(m_cap0 & m_mask)});
    chk("irq_any",  {31'd0, irq2}, {31'd0, |(m_cap2 & m_mask)});
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [1:0] a);
    chipselect = 1; write_n = 1; address = a;
    tick();
    chipselect = 0;
  endtask

  task automatic settle(input logic [7:0] v);
    in_port = v;
    repeat (LAT + 2) tick();
  endtask

  initial begin
    reset = 1; address = 0; chipselect = 0; write_n = 1; writedata = 0; in_port = 0;
    model_reset();
    #12;
    chk("reset_rd0", readdata0, 32'd0);
    chk("reset_rd2", readdata2, 32'd0);
    chk("reset_irq0", {31'd0, irq0}, 32'd0);
    chk("reset_irq2", {31'd0, irq2}, 32'd0);
    reset = 0;
    tick();

    // rising edge on bit 0 with mask bit 0
    wr(2'd2, 32'h01);
    in_port = 8'h01;
    repeat (LAT + 1) tick();
    chk("rise_irq", {31'd0, irq0}, 32'd1);
    rd(2'd3);
    chk("rise_cap", readdata0, 32'h1);

    // clear, and a zero write that must change nothing
    wr(2'd3, 32'h01);
    chk("clr_irq", {31'd0, irq0}, 32'd0);
    settle(8'h05);
    wr(2'd3, 32'h00);
    rd(2'd3);
    chk("clr0_keep", readdata0, 32'h04);

    // any-edge capture, data and reserved reads
    settle(8'h0F);
    wr(2'd3, 32'hFF);
    in_port = 8'hF0;
    repeat (LAT + 1) tick();
    rd(2'd3);
    chk("any_cap", readdata2, 32'hFF);
    rd(2'd0);
    chk("any_data", readdata2, 32'hF0);
    rd(2'd1);
    chk("rsvd", readdata2, 32'h0);

    // masking: pending capture, irq follows mask alone
    settle(8'h00);
    wr(2'd2, 32'h00);
    wr(2'd3, 32'hFF);
    settle(8'h80);
    chk("mask_off", {31'd0, irq0}, 32'd0);
    wr(2'd2, 32'h80);
    chk("mask_on", {31'd0, irq0}, 32'd1);
    wr(2'd2, 32'h00);
    chk("mask_drop", {31'd0, irq0}, 32'd0);
    rd(2'd3);
    chk("mask_keep", readdata0, 32'h80);

    // set wins over simultaneous clear on bit 2
    settle(8'h00);
    wr(2'd3, 32'hFF);
    in_port = 8'h04;
    repeat (LAT) tick();
    wr(2'd3, 32'h04);
    rd(2'd3);
    chk("set_wins", readdata0, 32'h04);

    // asynchronous reset mid-capture
    settle(8'h00);
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'hFF);
    settle(8'h3C);
    rd(2'd3);
    chk("pre_rst_cap", readdata0, 32'h3C);
    #2;
    reset = 1;
    in_port = 8'h01;
    #1;
    chk("arst_rd0", readdata0, 32'd0);
    chk("arst_irq0", {31'd0, irq0}, 32'd0);
    chk("arst_irq2", {31'd0, irq2}, 32'd0);
    model_reset();
    @(posedge clk); #2;
    reset = 0;
    repeat (LAT + 1) tick();
    rd(2'd3);
    chk("rel_cap", readdata0, 32'h01);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = $urandom_range(0, 2) != 0;
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
